// File: rtl/aligned_drain.sv
// aligned_drain: takes a total, rounds it up to a 2**ALIGN_BITS boundary and pays it out as
// aligned chunks of at most MAX_CHUNK. Define DRAIN_FAST_ROUND_EN to round in one step (no ROUND state).
//
// state | meaning
// IDLE  | waiting for a total on the input handshake
// ROUND | incrementing remaining up to the next alignment boundary
// EMIT  | presenting chunks until the final one is accepted
module aligned_drain #(
    parameter int WIDTH      = 8,
    parameter int ALIGN_BITS = 2,
    parameter int MAX_CHUNK  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             out_last,
    output logic [WIDTH-1:0] remaining,
    output logic             busy
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_CHUNK);
    localparam logic [WIDTH-1:0] LP_LOW = WIDTH'((1 << ALIGN_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             r_last;
    logic             w_last_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
`ifdef DRAIN_FAST_ROUND_EN
                    w_rem_nxt   = (din + LP_LOW) & ~LP_LOW;
                    w_state_nxt = S_EMIT;
`else
                    w_rem_nxt   = din;
                    w_state_nxt = ((din & LP_LOW) != '0) ? S_ROUND : S_EMIT;
`endif
                end
            end
            S_ROUND: begin
                w_rem_nxt = r_remaining + WIDTH'(1);
                if ((w_rem_nxt & LP_LOW) == '0) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_rem_nxt = r_remaining - r_dout;
                    if (r_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next beat is precomputed so dout/out_last come straight from flops.
    always_comb begin
        w_dout_nxt = '0;
        w_last_nxt = 1'b0;
        if (w_state_nxt == S_EMIT) begin
            w_dout_nxt = (w_rem_nxt > LP_MAX) ? LP_MAX : w_rem_nxt;
            w_last_nxt = (w_rem_nxt <= LP_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_dout      <= '0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_rem_nxt;
            r_dout      <= w_dout_nxt;
            r_last      <= w_last_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_EMIT);
    assign busy      = (r_state != S_IDLE);
    assign dout      = r_dout;
    assign out_last  = r_last;
    assign remaining = r_remaining;

endmodule

// File: tb/tb_aligned_drain.sv
// Scoreboard bench for aligned_drain: expected beats are derived from the rounded total
// and popped by an independent monitor on every accepted output beat.
module tb_aligned_drain;

    localparam int ALIGN = 4;
    localparam int MAXC  = 64;
    localparam int MODV  = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] din;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] dout;
    logic       out_last;
    logic [7:0] remaining;
    logic       busy;

    aligned_drain #(.WIDTH(8), .ALIGN_BITS(2), .MAX_CHUNK(64)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_last(out_last),
        .remaining(remaining), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        int last;
        int rem;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready
    bit    seen_last = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: round up with wrap, then split into MAXC-sized pieces.
    function automatic void push_expected(input int d);
        int r;
        beat_t b;
        r = (((d + ALIGN - 1) / ALIGN) * ALIGN) % MODV;
        if (r == 0) begin
            b.d = 0; b.last = 1; b.rem = 0;
            exp_q.push_back(b);
        end else begin
            while (r > 0) begin
                b.d    = (r > MAXC) ? MAXC : r;
                b.last = (r <= MAXC) ? 1 : 0;
                b.rem  = r;
                exp_q.push_back(b);
                r -= b.d;
            end
        end
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = (rdy_mode == 1);
        end
    end

    initial begin
        bit         prev_stall;
        logic [7:0] pd;
        logic [7:0] pr;
        logic       pl;
        beat_t      e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !out_valid) begin
                prev_stall = 1'b0;
            end else begin
                check("dout_aligned", int'(dout) % ALIGN, 0);
                check("dout_le_max", int'(dout <= MAXC), 1);
                if (prev_stall) begin
                    check("hold_dout", int'(dout), int'(pd));
                    check("hold_last", int'(out_last), int'(pl));
                    check("hold_remaining", int'(remaining), int'(pr));
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got dout=%0d, required no beat", dout);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_dout", int'(dout), e.d);
                        check("beat_last", int'(out_last), e.last);
                        check("beat_remaining", int'(remaining), e.rem);
                    end
                    if (out_last) seen_last = 1'b1;
                end
                prev_stall = !out_ready;
                pd = dout;
                pr = remaining;
                pl = out_last;
            end
        end
    end

    // Offers d once the block is idle, then measures cycles to the first out_valid.
    task automatic send(input int d);
        int lat;
        int k;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_send", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din      = 8'(d);
        push_expected(d);
        @(negedge clk);
        check("in_ready_accept", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
`ifdef DRAIN_FAST_ROUND_EN
        k = 0;
`else
        k = (ALIGN - (d % ALIGN)) % ALIGN;
`endif
        check("first_valid_latency", lat, 1 + k);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("drain_complete", int'(busy || exp_q.size() != 0), 0);
    endtask

    // Offer a word while busy; it must be refused.
    task automatic poke_busy();
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        din      = 8'($urandom_range(0, 255));
        @(negedge clk);
        check("in_ready_while_busy", int'(in_ready), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int dir_tab[11] = '{0, 1, 3, 4, 63, 64, 65, 128, 252, 253, 255};
        int d;
        reset    = 1'b1;
        in_valid = 1'b0;
        din      = '0;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_remaining", int'(remaining), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", int'(in_ready), 1);

        send(10);
        @(negedge clk);
        check("idle_after_single_beat", int'(busy), 0);
        wait_idle();

        send(200);
        wait_idle();

        send(254);
        wait_idle();

        rdy_mode = 2;
        @(posedge clk);
        #2;
        send(100);
        repeat (5) begin
            check("stall_dout", int'(dout), 64);
            check("stall_last", int'(out_last), 0);
            check("stall_remaining", int'(remaining), 100);
            @(negedge clk);
        end
        rdy_mode = 1;
        wait_idle();

        send(200);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        seen_last = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_remaining", int'(remaining), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 1);
        repeat (3) @(negedge clk);
        check("abort_no_last", int'(seen_last), 0);

        rdy_mode = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 11) d = dir_tab[i];
            else        d = int'($urandom_range(0, 255));
            send(d);
            if (!out_last && ($urandom_range(0, 1) == 1)) poke_busy();
            wait_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
